// File: rtl/spi_slave_if.sv
// Peripheral-bus port bundle for spi_slave: write strobe, address, write data
// and combinational read data.
interface spi_slave_if;
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_o;

  modport master (output data_i, output addr_i, output we_i, input data_o);
  modport slave  (input data_i, input addr_i, input we_i, output data_o);
endinterface

// File: rtl/spi_slave.sv
// Memory-mapped SPI slave: oversampled SCK/SS/MOSI, CPOL/CPHA modes 0-3, MSB-first bytes.
// Optional interrupt enable (CTRL[3]) and irq output under `define SPI_SLAVE_IRQ_EN.
module spi_slave #(
  parameter int unsigned CLK_RATIO = 8
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus,
  input  logic        spi_sck,
  input  logic        spi_ss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        irq
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [3:0] A_CTRL = 4'h0;
  localparam logic [3:0] A_TX   = 4'h4;
  localparam logic [3:0] A_RX   = 4'h8;
  localparam logic [3:0] A_ST   = 4'hC;

  localparam logic [7:0] MIN_GAP = 8'(CLK_RATIO / 2 - 1);

  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q;
  logic [0:0] state_q, state_d;
  logic       en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic [7:0] tx_hold_q, tx_hold_d, tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic       tx_empty_q, tx_empty_d, rx_valid_q, rx_valid_d, overrun_q, overrun_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       first_q, first_d, reload_q, reload_d;
  logic       miso_q, miso_oe_q;
  logic [7:0] gap_q;
  logic       irq_en_r;

  logic       sck_tgl, lead_edge, trail_edge, sample_edge, drive_edge;
  logic       ss_fall, ss_rise, mosi_s, busy;
  logic       load_tx, set_rx;
  logic [3:0] addr;
  logic [31:0] rdata;
  logic       unused_bits;

  assign unused_bits = ^{bus.addr_i[31:4], bus.data_i[31:8]};
  assign addr        = bus.addr_i[3:0];

  // Edges are judged between the 2nd and 3rd flops so MOSI (2 flops) lines up with SCK.
  assign sck_tgl     = sck_q[2] ^ sck_q[1];
  assign lead_edge   = sck_tgl & (sck_q[2] == cpol_q);
  assign trail_edge  = sck_tgl & (sck_q[1] == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign drive_edge  = cpha_q ? lead_edge  : trail_edge;
  assign ss_fall     = ss_q[2] & ~ss_q[1];
  assign ss_rise     = ~ss_q[2] & ss_q[1];
  assign mosi_s      = mosi_q[1];
  assign busy        = ~ss_q[1] & en_q;

`ifdef SPI_SLAVE_IRQ_EN
  logic irq_en_q, irq_en_d;
  assign irq_en_r = irq_en_q;
  assign irq      = irq_en_q & (rx_valid_q | overrun_q);
`else
  assign irq_en_r = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    en_d       = en_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    tx_hold_d  = tx_hold_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    tx_empty_d = tx_empty_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    bit_cnt_d  = bit_cnt_q;
    first_d    = first_q;
    reload_d   = reload_q;
    load_tx    = 1'b0;
    set_rx     = 1'b0;
`ifdef SPI_SLAVE_IRQ_EN
    irq_en_d   = irq_en_q;
`endif

    if (bus.we_i && addr == A_CTRL) begin
      en_d   = bus.data_i[0];
      cpol_d = bus.data_i[1];
      cpha_d = bus.data_i[2];
`ifdef SPI_SLAVE_IRQ_EN
      irq_en_d = bus.data_i[3];
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && en_q) begin
          state_d   = ST_ACTIVE;
          load_tx   = 1'b1;
          bit_cnt_d = 3'd0;
          first_d   = 1'b1;
          reload_d  = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise || !en_q) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
          reload_d  = 1'b0;
          first_d   = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_sh_d   = {rx_sh_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d = {rx_sh_q[6:0], mosi_s};
              set_rx    = 1'b1;
              reload_d  = 1'b1;
            end
          end
          if (drive_edge) begin
            if (reload_q) begin
              load_tx  = 1'b1;
              reload_d = 1'b0;
              first_d  = 1'b0;
            end else if (cpha_q && first_q) begin
              first_d = 1'b0;
            end else begin
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The shifter sees the old holding value; a same-cycle bus write still refills it.
    if (load_tx) begin
      tx_sh_d    = tx_empty_q ? 8'hFF : tx_hold_q;
      tx_empty_d = 1'b1;
    end
    if (bus.we_i && addr == A_TX) begin
      tx_hold_d  = bus.data_i[7:0];
      tx_empty_d = 1'b0;
    end

    if (bus.we_i && addr == A_ST) begin
      if (bus.data_i[0]) rx_valid_d = 1'b0;
      if (bus.data_i[1]) overrun_d  = 1'b0;
    end
    if (set_rx) begin
      rx_valid_d = 1'b1;
      if (rx_valid_q) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (!rst) begin
      sck_q      <= 3'b000;
      ss_q       <= 3'b111;
      mosi_q     <= 2'b00;
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_hold_q  <= 8'h00;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      tx_empty_q <= 1'b1;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      bit_cnt_q  <= 3'd0;
      first_q    <= 1'b0;
      reload_q   <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      gap_q      <= 8'd0;
`ifdef SPI_SLAVE_IRQ_EN
      irq_en_q   <= 1'b0;
`endif
    end else begin
      sck_q      <= {sck_q[1:0], spi_sck};
      ss_q       <= {ss_q[1:0], spi_ss};
      mosi_q     <= {mosi_q[0], spi_mosi};
      state_q    <= state_d;
      en_q       <= en_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      tx_hold_q  <= tx_hold_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      tx_empty_q <= tx_empty_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      bit_cnt_q  <= bit_cnt_d;
      first_q    <= first_d;
      reload_q   <= reload_d;
      miso_q     <= (state_q == ST_ACTIVE) & tx_sh_q[7];
      miso_oe_q  <= (state_q == ST_ACTIVE);
      if (sck_tgl)              gap_q <= 8'd0;
      else if (gap_q != 8'hFF)  gap_q <= gap_q + 8'd1;
`ifdef SPI_SLAVE_IRQ_EN
      irq_en_q   <= irq_en_d;
`endif
      // SCK half-periods shorter than CLK_RATIO/2 clocks would outrun the synchronizers.
      if (state_q == ST_ACTIVE && sck_tgl) assert (gap_q >= MIN_GAP);
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;

  always_comb begin
    rdata = 32'h0;
    case (addr)
      A_CTRL:  rdata = {28'h0, irq_en_r, cpha_q, cpol_q, en_q};
      A_TX:    rdata = {24'h0, tx_hold_q};
      A_RX:    rdata = {24'h0, rx_data_q};
      A_ST:    rdata = {28'h0, tx_empty_q, busy, overrun_q, rx_valid_q};
      default: rdata = 32'h0;
    endcase
    bus.data_o = rst ? rdata : 32'h0;
  end

endmodule
